// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES frame controller: FSM states, response
// status codes, key-length constants and the key-select encoding.
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RUN   = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } aes_state_e;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_BADLEN  = 8'h01;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h02;

  localparam logic [6:0] KEY_LEN_128 = 7'd16;
  localparam logic [6:0] KEY_LEN_192 = 7'd24;
  localparam logic [6:0] KEY_LEN_256 = 7'd32;

  localparam logic [1:0] KSEL_128 = 2'd0;
  localparam logic [1:0] KSEL_192 = 2'd1;
  localparam logic [1:0] KSEL_256 = 2'd2;

  // True when the header key length (in bytes) is one the core supports.
  function automatic logic key_len_valid(input logic [6:0] len);
    return (len == KEY_LEN_128) || (len == KEY_LEN_192) || (len == KEY_LEN_256);
  endfunction

  // Map a key length in bytes to the core key-select code; unsupported
  // lengths fall back to the 128-bit code (core_start never fires for them).
  function automatic logic [1:0] ksel_of_len(input logic [6:0] len);
    logic [1:0] ksel;
    case (len)
      KEY_LEN_192: ksel = KSEL_192;
      KEY_LEN_256: ksel = KSEL_256;
      default:     ksel = KSEL_128;
    endcase
    return ksel;
  endfunction

endpackage

// File: rtl/aes_watchdog.sv
// Cycle watchdog for the cipher core. Counts enabled cycles since the last
// clear; expired flags the enabled cycle whose increment reaches the limit,
// so an operation gets exactly 'limit' enabled cycles before abort.
module aes_watchdog #(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;
  logic [TO_W:0]   count_next;

  // Next count: clear wins, otherwise increment while enabled, saturating.
  always_comb begin
    count_next = {1'b0, count_q} + (TO_W+1)'(1);
    count_d    = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !count_next[TO_W]) begin
      count_d = count_next[TO_W-1:0];
    end
  end

  assign expired = enable && !clear && (count_next >= {1'b0, limit});

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/aes_frame_ctrl.sv
// Frame controller between an SPI slave and an iterative AES core. Accepts a
// request frame, validates the key length, launches the core, guards it with a
// watchdog and returns either the result or an error status frame.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_frame, accepted only
// in IDLE (otherwise counted in ovr_cnt); core_start and tx_load are one-cycle
// strobes; core_done is honoured only in RUN; there is no back-pressure.
module aes_frame_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int KEY_W   = 256,
  parameter int FRAME_W = DATA_W + 8 + KEY_W,
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] rx_frame,
  input  logic               rx_valid,
  output logic               core_start,
  output logic               core_mode,
  output logic [1:0]         core_ksel,
  output logic [DATA_W-1:0]  core_data,
  output logic [KEY_W-1:0]   core_key,
  input  logic               core_done,
  input  logic [DATA_W-1:0]  core_result,
  output logic [FRAME_W-1:0] tx_frame,
  output logic               tx_load,
  output logic               busy,
  output logic [7:0]         ovr_cnt,
  output aes_state_e         dbg_state
);

  aes_state_e         state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [7:0]         hdr_q, hdr_d;
  logic [FRAME_W-1:0] tx_frame_q, tx_frame_d;
  logic [7:0]         ovr_q, ovr_d;

  logic len_ok;
  logic wd_clear;
  logic wd_en;
  logic wd_expired;

  assign len_ok = key_len_valid(hdr_q[6:0]);

  aes_watchdog #(
    .TO_W(TO_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_en),
    .limit  (TO_W'(TIMEOUT)),
    .expired(wd_expired)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      key_q      <= '0;
      hdr_q      <= '0;
      tx_frame_q <= '0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      key_q      <= key_d;
      hdr_q      <= hdr_d;
      tx_frame_q <= tx_frame_d;
      ovr_q      <= ovr_d;
    end
  end

  // Next state, operand capture, response frame build and overrun counting.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    key_d      = key_q;
    hdr_d      = hdr_q;
    tx_frame_d = tx_frame_q;
    ovr_d      = ovr_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          data_d  = rx_frame[FRAME_W-1 -: DATA_W];
          hdr_d   = rx_frame[KEY_W+7:KEY_W];
          key_d   = rx_frame[KEY_W-1:0];
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (len_ok) begin
          state_d = ST_RUN;
        end else begin
          tx_frame_d = {{DATA_W{1'b0}}, STATUS_BADLEN, {KEY_W{1'b0}}};
          state_d    = ST_ERR;
        end
      end
      ST_RUN: begin
        // A result arriving on the expiry edge still counts as success.
        if (core_done) begin
          tx_frame_d = {core_result, STATUS_OK, {KEY_W{1'b0}}};
          state_d    = ST_RESP;
        end else if (wd_expired) begin
          tx_frame_d = {{DATA_W{1'b0}}, STATUS_TIMEOUT, {KEY_W{1'b0}}};
          state_d    = ST_ERR;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Frames arriving while an operation is in flight are dropped and counted.
    if (rx_valid && (state_q != ST_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    core_start = 1'b0;
    wd_clear   = 1'b0;
    wd_en      = 1'b0;
    tx_load    = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_CHECK: begin
        core_start = len_ok;
        wd_clear   = 1'b1;
      end
      ST_RUN:  wd_en   = 1'b1;
      ST_RESP: tx_load = 1'b1;
      ST_ERR:  tx_load = 1'b1;
      default: ;
    endcase
  end

  assign core_mode = hdr_q[7];
  assign core_ksel = ksel_of_len(hdr_q[6:0]);
  assign core_data = data_q;
  assign core_key  = key_q;
  assign tx_frame  = tx_frame_q;
  assign ovr_cnt   = ovr_q;
  assign dbg_state = state_q;

endmodule

// File: doc/aes_frame_ctrl.md
AES_FRAME_CTRL -- requirements
Module: aes_frame_ctrl

Interface
REQ-001 Parameter DATA_W, 128, block width in bits.
REQ-002 Parameter KEY_W, 256, maximum key field width in bits.
REQ-003 Parameter FRAME_W, DATA_W+8+KEY_W (392), SPI frame width in bits.
REQ-004 Parameter TIMEOUT, 1000, maximum core cycles before abort; TO_W, 16, counter width.
REQ-005 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 rx_frame  in  FRAME_W  frame from the SPI slave: data [FRAME_W-1 -: DATA_W], header [KEY_W+7:KEY_W], key [KEY_W-1:0], left-aligned.
REQ-008 rx_valid  in  1  single-cycle pulse; rx_frame is valid.
REQ-009 core_start  out  1  single-cycle launch pulse to the iterative cipher core.
REQ-010 core_mode  out  1  0 = encrypt, 1 = decrypt.
REQ-011 core_ksel  out  2  0 = 128-bit, 1 = 192-bit, 2 = 256-bit key.
REQ-012 core_data, core_key  out  DATA_W, KEY_W  latched operands, held stable from core_start until the next accepted frame.
REQ-013 core_done  in  1  core result valid pulse; core_result  in  DATA_W.
REQ-014 tx_frame  out  FRAME_W  response frame to the SPI slave; tx_load  out  1  single-cycle load pulse.
REQ-015 busy  out  1  high in every state except IDLE; ovr_cnt  out  8  dropped-frame count.

Function
REQ-016 Header byte: bit7 = mode; bits[6:0] = key length in bytes, valid values 16, 24, 32 only.
REQ-017 FSM states: IDLE, CHECK, RUN, RESP, ERR.
REQ-018 IDLE: on rx_valid, register rx_frame and go to CHECK on the next edge.
REQ-019 CHECK, valid length: assert core_start for exactly this one cycle, clear the watchdog, then go to RUN.
REQ-020 CHECK, invalid length: go to ERR with status 0x01; core_start SHALL NOT assert.
REQ-021 RUN: when core_done is sampled high, capture core_result and go to RESP.
REQ-022 RUN: the watchdog increments every cycle; when it reaches TIMEOUT with core_done low, go to ERR with status 0x02.
REQ-023 RUN: if core_done and the timeout occur in the same cycle, core_done SHALL win.
REQ-024 RESP: tx_frame = {result, 8'h00, KEY_W zeros}; tx_load = 1 for one cycle; then go to IDLE.
REQ-025 ERR: tx_frame = {DATA_W zeros, status, KEY_W zeros}; tx_load = 1 for one cycle; then go to IDLE.
REQ-026 tx_frame SHALL hold its value until the next tx_load.
REQ-027 Latency: rx_valid at edge N gives core_start in cycle N+1; core_done at edge M gives tx_load in cycle M+1.
REQ-028 rx_valid outside IDLE: drop the frame and increment ovr_cnt, saturating at 255; the current operation SHALL be unaffected.
REQ-029 core_done outside RUN SHALL be ignored.

Reset
REQ-030 On reset: state IDLE, and core_start, tx_load, busy, ovr_cnt, watchdog, tx_frame, core_data, core_key, core_mode and core_ksel all zero.
REQ-031 Reset asserted mid-RUN aborts the operation with no tx_load; a later core_done SHALL be ignored.

Structure
REQ-032 Shared package aes_ctrl_pkg SHALL hold the state enum, status codes (0x00 OK, 0x01 BADLEN, 0x02 TIMEOUT), key-length constants (16/24/32) and the ksel encoding.
REQ-033 The watchdog counter SHALL be one sub-module, aes_watchdog (clear, enable, limit, expired), parametrised by TO_W.

Verification
REQ-034 Encrypt: data 00112233445566778899aabbccddeeff, header 0x10, key 000102030405060708090a0b0c0d0e0f left-aligned; core model done after 10 cycles returning 69c4e0d86a7b0430d8cdb78070b4c55a -> core_mode 0, core_ksel 0, tx_frame[391:264] equals that value, status 0x00, tx_load one cycle.
REQ-035 Decrypt 256-bit: header 0xA0 -> core_mode 1, core_ksel 2, core_key equals the full 256-bit field; the returned result is echoed in tx_frame.
REQ-036 Bad length: header 0x14 -> no core_start; tx_frame[263:256] = 0x01, data field zero, tx_load 2 cycles after rx_valid.
REQ-037 Timeout: core never asserts done, TIMEOUT = 20 -> status 0x02, busy deasserts 1 cycle after tx_load; core_done at the same edge as expiry -> status 0x00.
REQ-038 Overrun: three rx_valid pulses during RUN -> ovr_cnt = 3, response unchanged; 300 pulses -> ovr_cnt = 255.
REQ-039 Reset mid-RUN, then core_done -> no tx_load, busy 0, outputs at reset values; the next frame completes normally.
